// File: rtl/img_pattern_src.sv
// Video test-pattern source: vsync/hsync/valid/data stream with programmable timing,
// four selectable patterns and optional LFSR salt-and-pepper noise.
//
//   state  | meaning
//   IDLE   | waiting for enable; all strobes low
//   ACTIVE | emitting pixels x=0..H_ACTIVE-1 of line y
//   HBLANK | horizontal blanking after line y (vsync still high)
//   VBLANK | V_BLANK blank lines; frame_done on the final cycle
module img_pattern_src #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_BLANK   = 160,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_BLANK   = 45,
    parameter logic [7:0]  CONST_VAL = 8'h80,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic        noise_en,
    input  logic [7:0]  noise_thresh,
    output logic        img_vsync,
    output logic        img_hsync,
    output logic        img_valid,
    output logic [7:0]  img_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int Y_MAX   = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int YW      = $clog2(Y_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [1:0]    sel_q, sel_d;
    logic          nen_q, nen_d;
    logic [7:0]    thr_q, thr_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic          vsync_q, vsync_d;
    logic          hsync_q, hsync_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;
    logic [15:0]   fcnt_q, fcnt_d;

    logic [7:0]    x8, y8, pat_val, pix;
    logic          lfsr_fb;

    // x/y are narrower or wider than a byte depending on timing; patterns use the low byte.
    always_comb begin
        x8 = 8'(x_q);
        y8 = 8'(y_q);
        unique case (sel_q)
            2'd0:    pat_val = x8;
            2'd1:    pat_val = y8;
            2'd2:    pat_val = (x8[3] ^ y8[3]) ? 8'hFF : 8'h00;
            default: pat_val = CONST_VAL;
        endcase
        if (nen_q && (lfsr_q[15:8] < thr_q))
            pix = lfsr_q[0] ? 8'hFF : 8'h00;
        else
            pix = pat_val;
    end

    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        sel_d   = sel_q;
        nen_d   = nen_q;
        thr_d   = thr_q;
        lfsr_d  = lfsr_q;
        vsync_d = 1'b0;
        hsync_d = 1'b0;
        data_d  = 8'h00;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    sel_d   = pattern_sel;
                    nen_d   = noise_en;
                    thr_d   = noise_thresh;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                vsync_d = 1'b1;
                hsync_d = 1'b1;
                data_d  = pix;
                // Advancing here keeps the LFSR in step with the registered valid strobe.
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                if (x_q == XW'(H_ACTIVE - 1)) begin
                    x_d     = '0;
                    state_d = HBLANK;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            HBLANK: begin
                vsync_d = 1'b1;
                if (x_q == XW'(H_BLANK - 1)) begin
                    x_d = '0;
                    if (y_q == YW'(V_ACTIVE - 1)) begin
                        y_d     = '0;
                        state_d = VBLANK;
                    end else begin
                        y_d     = y_q + 1'b1;
                        state_d = ACTIVE;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            VBLANK: begin
                if (x_q == XW'(H_TOTAL - 1)) begin
                    x_d = '0;
                    if (y_q == YW'(V_BLANK - 1)) begin
                        y_d    = '0;
                        done_d = 1'b1;
                        fcnt_d = fcnt_q + 16'd1;
                        if (enable) begin
                            sel_d   = pattern_sel;
                            nen_d   = noise_en;
                            thr_d   = noise_thresh;
                            state_d = ACTIVE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            sel_q   <= 2'd0;
            nen_q   <= 1'b0;
            thr_q   <= 8'h00;
            lfsr_q  <= LFSR_SEED;
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            fcnt_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            nen_q   <= nen_d;
            thr_q   <= thr_d;
            lfsr_q  <= lfsr_d;
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign img_vsync  = vsync_q;
    assign img_hsync  = hsync_q;
    assign img_valid  = hsync_q;
    assign img_data   = data_q;
    assign frame_done = done_q;
    assign frame_cnt  = fcnt_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_img_pattern_src.sv
// Directed bench for img_pattern_src with a 4x3 active / 24-cycle frame.
module tb_img_pattern_src;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        noise_en;
    logic [7:0]  noise_thresh;
    logic        img_vsync, img_hsync, img_valid, frame_done, busy;
    logic [7:0]  img_data;
    logic [15:0] frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    img_pattern_src #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3), .V_BLANK(1),
        .CONST_VAL(8'h80), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .noise_en(noise_en), .noise_thresh(noise_thresh),
        .img_vsync(img_vsync), .img_hsync(img_hsync), .img_valid(img_valid),
        .img_data(img_data), .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {vsync, hsync, valid, frame_done, data} for output cycle i (0..23) of a noise-free frame
    function automatic logic [11:0] exp_vec(input int i, input int pat);
        int x, y;
        logic vs, hs;
        logic [7:0] d;
        y  = i / 6;
        x  = i % 6;
        vs = (i < 18);
        hs = vs && (x < 4);
        d  = 8'h00;
        if (hs) begin
            case (pat)
                0: d = 8'(x);
                1: d = 8'(y);
                2: d = (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
                default: d = 8'h80;
            endcase
        end
        return {vs, hs, hs, (i == 23), d};
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {img_vsync, img_hsync, img_valid, frame_done, img_data};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; pattern_sel = 2'd0;
        noise_en = 1'b0; noise_thresh = 8'h00;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; pattern_sel = 2'd0;
        noise_en = 1'b0; noise_thresh = 8'h00;
        tick(); tick(); tick();
        n_checks++;
        if ({obs_vec(), frame_cnt, busy} !== 29'd0)
            $display("FAIL reset_outputs: got %h, want 0", {obs_vec(), frame_cnt, busy});
        else n_pass++;
        enable = 1'b0;
        rst_n  = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b, want 0", busy);
        else n_pass++;
    endtask

    task automatic test_single_frame();
        logic [11:0] e;
        int any_valid;
        do_reset();
        enable = 1'b1; pattern_sel = 2'd0;
        tick();
        enable = 1'b0;
        n_checks++;
        if (img_valid !== 1'b0 || img_vsync !== 1'b0)
            $display("FAIL single_latency: valid=%b vsync=%b, want 0 0", img_valid, img_vsync);
        else n_pass++;
        for (int i = 0; i < 24; i++) begin
            tick();
            e = exp_vec(i, 0);
            n_checks++;
            if (obs_vec() !== e) $display("FAIL single_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
        end
        n_checks++;
        if (frame_cnt !== 16'd1 || busy !== 1'b0)
            $display("FAIL single_end: frame_cnt=%0d busy=%b, want 1 0", frame_cnt, busy);
        else n_pass++;
        any_valid = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (img_valid || img_vsync || frame_done) any_valid++;
        end
        n_checks++;
        if (any_valid !== 0) $display("FAIL single_idle_quiet: active cycles %0d, want 0", any_valid);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] e;
        int last_done;
        last_done = -1;
        do_reset();
        enable = 1'b1; pattern_sel = 2'd2;
        tick();
        for (int i = 0; i < 72; i++) begin
            tick();
            e = exp_vec(i % 24, 2);
            n_checks++;
            if (obs_vec() !== e) $display("FAIL b2b_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
            if (frame_done) begin
                n_checks++;
                if (frame_cnt !== 16'(i / 24 + 1))
                    $display("FAIL b2b_cnt: got %0d, want %0d", frame_cnt, i / 24 + 1);
                else n_pass++;
                if (last_done >= 0) begin
                    n_checks++;
                    if (i - last_done !== 24)
                        $display("FAIL b2b_spacing: got %0d, want 24", i - last_done);
                    else n_pass++;
                end
                last_done = i;
            end
            if (i == 50) enable = 1'b0;
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || img_valid !== 1'b0 || frame_cnt !== 16'd3)
            $display("FAIL b2b_end: busy=%b valid=%b cnt=%0d, want 0 0 3", busy, img_valid, frame_cnt);
        else n_pass++;
    endtask

    task automatic test_pattern_change();
        logic [11:0] e;
        do_reset();
        enable = 1'b1; pattern_sel = 2'd0;
        tick();
        for (int i = 0; i < 48; i++) begin
            tick();
            e = exp_vec(i % 24, (i < 24) ? 0 : 1);
            n_checks++;
            if (obs_vec() !== e) $display("FAIL patchg_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
            if (i == 8)  pattern_sel = 2'd1;
            if (i == 30) enable = 1'b0;
        end
        n_checks++;
        if (busy !== 1'b0 || frame_cnt !== 16'd2)
            $display("FAIL patchg_end: busy=%b cnt=%0d, want 0 2", busy, frame_cnt);
        else n_pass++;
    endtask

    task automatic test_noise();
        logic [11:0] e;
        logic [15:0] ref_l;
        do_reset();
        noise_en = 1'b1; noise_thresh = 8'hFF; pattern_sel = 2'd3; enable = 1'b1;
        tick();
        enable = 1'b0;
        ref_l = 16'hACE1;
        for (int i = 0; i < 24; i++) begin
            tick();
            e = exp_vec(i, 3);
            if (e[10]) begin
                e[7:0] = (ref_l[15:8] < 8'hFF) ? (ref_l[0] ? 8'hFF : 8'h00) : 8'h80;
                ref_l  = lfsr_next(ref_l);
            end
            n_checks++;
            if (obs_vec() !== e) $display("FAIL noise_ff_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
        end
        tick();
        noise_thresh = 8'h00; enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 24; i++) begin
            tick();
            e = exp_vec(i, 3);
            n_checks++;
            if (obs_vec() !== e) $display("FAIL noise_zero_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [11:0] e;
        logic [15:0] ref_l;
        do_reset();
        enable = 1'b1; pattern_sel = 2'd0;
        tick();
        enable = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            e = exp_vec(i, 0);
            n_checks++;
            if (obs_vec() !== e) $display("FAIL midrst_pre_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({obs_vec(), frame_cnt, busy} !== 29'd0)
            $display("FAIL midrst_outputs: got %h, want 0", {obs_vec(), frame_cnt, busy});
        else n_pass++;
        rst_n = 1'b1;
        noise_en = 1'b1; noise_thresh = 8'h80; pattern_sel = 2'd0; enable = 1'b1;
        tick();
        enable = 1'b0;
        ref_l = 16'hACE1;
        for (int i = 0; i < 24; i++) begin
            tick();
            e = exp_vec(i, 0);
            if (e[10]) begin
                if (ref_l[15:8] < 8'h80) e[7:0] = ref_l[0] ? 8'hFF : 8'h00;
                ref_l = lfsr_next(ref_l);
            end
            n_checks++;
            if (obs_vec() !== e) $display("FAIL midrst_post_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
        end
        n_checks++;
        if (frame_cnt !== 16'd1) $display("FAIL midrst_cnt: got %0d, want 1", frame_cnt);
        else n_pass++;
    endtask

    task automatic test_enable_drop();
        logic [11:0] e;
        int any_valid;
        do_reset();
        enable = 1'b1; pattern_sel = 2'd1;
        tick();
        for (int i = 0; i < 24; i++) begin
            tick();
            e = exp_vec(i, 1);
            n_checks++;
            if (obs_vec() !== e) $display("FAIL endrop_cyc%0d: got %h, want %h", i, obs_vec(), e);
            else n_pass++;
            if (i == 6) enable = 1'b0;
        end
        any_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (img_valid || img_vsync || frame_done || busy) any_valid++;
        end
        n_checks++;
        if (any_valid !== 0 || frame_cnt !== 16'd1)
            $display("FAIL endrop_idle: active=%0d cnt=%0d, want 0 1", any_valid, frame_cnt);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_pattern_change();
        test_noise();
        test_mid_reset();
        test_enable_drop();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
